// File: rtl/scan_pkg.sv
// Shared definitions for the pixel scan controller: FSM encoding, size defaults
// and the decimation stride helper.
package scan_pkg;

  localparam int unsigned MaxWDefault = 640;
  localparam int unsigned MaxHDefault = 480;
  localparam int unsigned StepW       = 2;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StDrain,
    StDone
  } scan_state_e;

  // Low-bit mask of a power-of-two stride: (1 << step) - 1.
  function automatic int unsigned step_mask(input logic [StepW-1:0] step);
    return (32'd1 << step) - 32'd1;
  endfunction

endpackage

// File: rtl/pixel_scan_ctrl_if.sv
// Pixel stream in/out handshake bundle. The controller uses the slave side; the
// pixel source and downstream sink sit on the master side.
interface pixel_scan_ctrl_if
  import scan_pkg::*;
#(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned X_W   = $clog2(MaxWDefault),
  parameter int unsigned Y_W   = $clog2(MaxHDefault)
) ();

  logic             in_valid;
  logic [PIX_W-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_data;
  logic [X_W-1:0]   out_x;
  logic [Y_W-1:0]   out_y;
  logic             out_last;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_x,
    input  out_y,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_x,
    output out_y,
    output out_last
  );

endinterface

// File: rtl/raster_counter.sv
// Raster x/y position counter bounded by a runtime width/height. Freezes on the
// final pixel until cleared.
module raster_counter #(
  parameter int unsigned X_W = 10,
  parameter int unsigned Y_W = 9
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           clr_i,
  input  logic           inc_i,
  input  logic [X_W:0]   width_i,
  input  logic [Y_W:0]   height_i,
  output logic [X_W-1:0] x_o,
  output logic [Y_W-1:0] y_o,
  output logic           wrap_o,
  output logic           last_o
);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           final_px;

  // wrap_o: at the end of a row; last_o: on the last row.
  assign wrap_o   = ({1'b0, x_q} == (width_i - (X_W+1)'(1)));
  assign last_o   = ({1'b0, y_q} == (height_i - (Y_W+1)'(1)));
  assign final_px = wrap_o && last_o;
  assign x_o      = x_q;
  assign y_o      = y_q;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr_i) begin
      x_d = '0;
      y_d = '0;
    end else if (inc_i && !final_px) begin
      if (wrap_o) begin
        x_d = '0;
        y_d = y_q + Y_W'(1);
      end else begin
        x_d = x_q + X_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/pixel_scan_ctrl.sv
// Frame scan controller: walks a runtime-sized raster over a pixel stream,
// decimates by a power-of-two stride and forwards kept pixels with coordinates.
module pixel_scan_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned MAX_W = MaxWDefault,
  parameter int unsigned MAX_H = MaxHDefault,
  parameter int unsigned PIX_W = 8,
  parameter int unsigned X_W   = $clog2(MAX_W),
  parameter int unsigned Y_W   = $clog2(MAX_H)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [X_W:0]     cfg_width_i,
  input  logic [Y_W:0]     cfg_height_i,
  input  logic [StepW-1:0] cfg_step_log2_i,
  pixel_scan_ctrl_if.slave pix_if,
  output logic             busy_o,
  output logic             done_o,
  output logic             cfg_err_o
);

  scan_state_e      state_q, state_d;
  logic [X_W:0]     width_q, width_d;
  logic [Y_W:0]     height_q, height_d;
  logic [StepW-1:0] step_q, step_d;
  logic             cfg_err_q, cfg_err_d;
  logic             out_valid_q, out_valid_d;
  logic [PIX_W-1:0] out_data_q, out_data_d;
  logic [X_W-1:0]   out_x_q, out_x_d;
  logic [Y_W-1:0]   out_y_q, out_y_d;
  logic             out_last_q, out_last_d;

  logic             cfg_ok, cfg_ld, in_ready, accept, keep, cnt_clr;
  logic [X_W-1:0]   cnt_x, mask_x, last_x;
  logic [Y_W-1:0]   cnt_y, mask_y, last_y;
  logic             cnt_wrap, cnt_last_row, final_px;

  assign cfg_ok = (cfg_width_i != '0) && (cfg_height_i != '0) &&
                  (cfg_width_i <= (X_W+1)'(MAX_W)) && (cfg_height_i <= (Y_W+1)'(MAX_H));

  assign in_ready = (state_q == StRun) && (!out_valid_q || pix_if.out_ready);
  assign accept   = pix_if.in_valid && in_ready;
  assign final_px = cnt_wrap && cnt_last_row;
  assign cnt_clr  = abort_i || cfg_ld || (state_q == StDone);

  raster_counter #(
    .X_W (X_W),
    .Y_W (Y_W)
  ) u_raster_counter (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (cnt_clr),
    .inc_i    (accept),
    .width_i  (width_q),
    .height_i (height_q),
    .x_o      (cnt_x),
    .y_o      (cnt_y),
    .wrap_o   (cnt_wrap),
    .last_o   (cnt_last_row)
  );

  // Decimation: keep when the stride's low bits are zero; the last kept pixel
  // sits at the frame's far corner rounded down to the stride grid.
  assign mask_x = X_W'(step_mask(step_q));
  assign mask_y = Y_W'(step_mask(step_q));
  assign keep   = ((cnt_x & mask_x) == '0) && ((cnt_y & mask_y) == '0);
  assign last_x = X_W'(width_q - (X_W+1)'(1)) & ~mask_x;
  assign last_y = Y_W'(height_q - (Y_W+1)'(1)) & ~mask_y;

  always_comb begin
    state_d   = state_q;
    cfg_ld    = 1'b0;
    cfg_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i && !abort_i) begin
          if (cfg_ok) begin
            state_d = StLoad;
            cfg_ld  = 1'b1;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      StLoad:  state_d = StRun;
      StRun:   if (accept && final_px) state_d = StDrain;
      StDrain: if (!out_valid_q || pix_if.out_ready) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort_i && (state_q != StIdle)) begin
      state_d = StIdle;
    end
  end

  always_comb begin
    width_d  = width_q;
    height_d = height_q;
    step_d   = step_q;
    if (cfg_ld) begin
      width_d  = cfg_width_i;
      height_d = cfg_height_i;
      step_d   = cfg_step_log2_i;
    end
  end

  // A new kept pixel overrides the clear from a same-cycle output handshake.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    out_last_d  = out_last_q;
    if (abort_i) begin
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_x_d     = '0;
      out_y_d     = '0;
      out_last_d  = 1'b0;
    end else if (accept && keep) begin
      out_valid_d = 1'b1;
      out_data_d  = pix_if.in_data;
      out_x_d     = cnt_x;
      out_y_d     = cnt_y;
      out_last_d  = (cnt_x == last_x) && (cnt_y == last_y);
    end else if (pix_if.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      width_q     <= '0;
      height_q    <= '0;
      step_q      <= '0;
      cfg_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      width_q     <= width_d;
      height_q    <= height_d;
      step_q      <= step_d;
      cfg_err_q   <= cfg_err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      out_last_q  <= out_last_d;
    end
  end

  assign pix_if.in_ready  = in_ready;
  assign pix_if.out_valid = out_valid_q;
  assign pix_if.out_data  = out_data_q;
  assign pix_if.out_x     = out_x_q;
  assign pix_if.out_y     = out_y_q;
  assign pix_if.out_last  = out_last_q;

  assign busy_o    = (state_q == StLoad) || (state_q == StRun) || (state_q == StDrain);
  assign done_o    = (state_q == StDone);
  assign cfg_err_o = cfg_err_q;

endmodule

// File: tb/tb_pixel_scan_ctrl.sv
// Directed bench for pixel_scan_ctrl: config-reject table, frame table with
// hand-listed beats, plus abort and mid-frame reset sequences.
module tb_pixel_scan_ctrl;
  import scan_pkg::*;

  localparam int unsigned MAX_W = 640;
  localparam int unsigned MAX_H = 480;
  localparam int unsigned PIX_W = 8;
  localparam int unsigned X_W   = $clog2(MAX_W);
  localparam int unsigned Y_W   = $clog2(MAX_H);

  logic             clk = 1'b0;
  logic             rst_ni = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [X_W:0]     cfg_w = '0;
  logic [Y_W:0]     cfg_h = '0;
  logic [StepW-1:0] cfg_s = '0;
  logic             busy, done, cfg_err;

  pixel_scan_ctrl_if #(.PIX_W(PIX_W), .X_W(X_W), .Y_W(Y_W)) pif ();

  pixel_scan_ctrl #(
    .MAX_W (MAX_W),
    .MAX_H (MAX_H),
    .PIX_W (PIX_W),
    .X_W   (X_W),
    .Y_W   (Y_W)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .start_i         (start),
    .abort_i         (abort),
    .cfg_width_i     (cfg_w),
    .cfg_height_i    (cfg_h),
    .cfg_step_log2_i (cfg_s),
    .pix_if          (pif),
    .busy_o          (busy),
    .done_o          (done),
    .cfg_err_o       (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; int d; int l; } beat_t;
  typedef struct { int w; int h; int ab; int err; } cfg_vec_t;
  typedef struct { int w; int h; int s; int toggle; } frame_vec_t;

  beat_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_beat(input int x, input int y, input int w, input int l);
    beat_t b;
    b.x = x; b.y = y; b.d = (y * w + x) & 255; b.l = l;
    exp_q.push_back(b);
  endtask

  task automatic build_exp(input int idx);
    exp_q.delete();
    case (idx)
      0: for (int i = 0; i < 16; i++) push_beat(i % 4, i / 4, 4, int'(i == 15));
      1: begin
        push_beat(0, 0, 4, 0); push_beat(2, 0, 4, 0);
        push_beat(0, 2, 4, 0); push_beat(2, 2, 4, 1);
      end
      default: begin
        push_beat(0, 0, 5, 0); push_beat(2, 0, 5, 0); push_beat(4, 0, 5, 0);
        push_beat(0, 2, 5, 0); push_beat(2, 2, 5, 0); push_beat(4, 2, 5, 1);
      end
    endcase
  endtask

  // Drives one full frame and checks beats, stalls, busy and done timing.
  task automatic run_frame(input int w, input int h, input int s, input int toggle);
    int    npix = w * h;
    int    pix = 0;
    int    nb = 0;
    int    last_hs = -10;
    int    last_acc = -10;
    int    exp_done;
    bit    stalled = 1'b0;
    bit    finished = 1'b0;
    beat_t held;
    beat_t e;
    @(negedge clk);
    cfg_w = (X_W+1)'(w); cfg_h = (Y_W+1)'(h); cfg_s = StepW'(s); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("busy_in_load", busy, 1);
    check("in_ready_in_load", pif.in_ready, 0);
    for (int t = 0; t < 400 && !finished; t++) begin
      @(negedge clk);
      pif.out_ready = (toggle != 0) ? ((t % 4 == 0) || (t % 4 == 3)) : 1'b1;
      pif.in_valid  = (pix < npix);
      pif.in_data   = PIX_W'(pix);
      #1;
      if (stalled) begin
        check("hold_valid", pif.out_valid, 1);
        check("hold_x", pif.out_x, held.x);
        check("hold_y", pif.out_y, held.y);
        check("hold_data", pif.out_data, held.d);
        check("hold_last", pif.out_last, held.l);
      end
      if (pif.out_valid && !pif.out_ready) check("in_ready_stall", pif.in_ready, 0);
      if (pif.out_valid && pif.out_ready) begin
        if (nb < exp_q.size()) begin
          e = exp_q[nb];
          check("beat_x", pif.out_x, e.x);
          check("beat_y", pif.out_y, e.y);
          check("beat_data", pif.out_data, e.d);
          check("beat_last", pif.out_last, e.l);
        end else begin
          check("extra_beat", nb + 1, exp_q.size());
        end
        nb++;
        last_hs = t;
      end
      stalled = pif.out_valid && !pif.out_ready;
      held.x = pif.out_x; held.y = pif.out_y; held.d = pif.out_data; held.l = pif.out_last;
      if (pif.in_valid && pif.in_ready) begin
        pix++;
        if (pix == npix) last_acc = t;
      end
      if (done) begin
        exp_done = (last_hs + 1 > last_acc + 2) ? last_hs + 1 : last_acc + 2;
        check("done_timing", t, exp_done);
        check("busy_at_done", busy, 0);
        finished = 1'b1;
      end else begin
        check("busy_in_frame", busy, 1);
      end
    end
    check("frame_finished", finished, 1);
    check("pixels_consumed", pix, npix);
    check("beat_count", nb, exp_q.size());
    pif.in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_cfg_err"}, cfg_err, 0);
    check({tag, "_in_ready"}, pif.in_ready, 0);
    check({tag, "_out_valid"}, pif.out_valid, 0);
    check({tag, "_out_data"}, pif.out_data, 0);
    check({tag, "_out_x"}, pif.out_x, 0);
    check({tag, "_out_y"}, pif.out_y, 0);
    check({tag, "_out_last"}, pif.out_last, 0);
  endtask

  cfg_vec_t   cfg_tab[5];
  frame_vec_t frame_tab[3];

  initial begin
    int pix;
    cfg_tab[0] = '{w: 0,   h: 4,   ab: 0, err: 1};
    cfg_tab[1] = '{w: 4,   h: 481, ab: 0, err: 1};
    cfg_tab[2] = '{w: 641, h: 4,   ab: 0, err: 1};
    cfg_tab[3] = '{w: 4,   h: 0,   ab: 0, err: 1};
    cfg_tab[4] = '{w: 4,   h: 4,   ab: 1, err: 0};
    frame_tab[0] = '{w: 4, h: 4, s: 0, toggle: 0};
    frame_tab[1] = '{w: 4, h: 4, s: 1, toggle: 0};
    frame_tab[2] = '{w: 5, h: 3, s: 1, toggle: 1};

    pif.in_valid = 1'b0; pif.in_data = '0; pif.out_ready = 1'b0;
    #12;
    check_idle_outputs("in_reset");
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    check_idle_outputs("after_reset");

    // Rejected configurations, and start+abort together in IDLE.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cfg_w = (X_W+1)'(cfg_tab[i].w); cfg_h = (Y_W+1)'(cfg_tab[i].h); cfg_s = '0;
      start = 1'b1; abort = cfg_tab[i].ab[0];
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      #1;
      check("cfg_err_pulse", cfg_err, cfg_tab[i].err);
      check("cfg_busy", busy, 0);
      check("cfg_in_ready", pif.in_ready, 0);
      @(negedge clk);
      #1;
      check("cfg_err_cleared", cfg_err, 0);
      check("cfg_busy_later", busy, 0);
    end

    for (int i = 0; i < 3; i++) begin
      build_exp(i);
      run_frame(frame_tab[i].w, frame_tab[i].h, frame_tab[i].s, frame_tab[i].toggle);
    end

    // Abort after the 6th accept of a 4x4 frame.
    @(negedge clk);
    cfg_w = 5'd4; cfg_h = 4'd4; cfg_s = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pix = 0;
    for (int t = 0; t < 50 && pix < 6; t++) begin
      @(negedge clk);
      pif.out_ready = 1'b1; pif.in_valid = 1'b1; pif.in_data = PIX_W'(pix);
      #1;
      if (pif.in_valid && pif.in_ready) pix++;
    end
    check("abort_setup_accepts", pix, 6);
    @(negedge clk);
    abort = 1'b1;
    #1;
    check("abort_pre_out_valid", pif.out_valid, 1);
    check("abort_pre_busy", busy, 1);
    @(negedge clk);
    abort = 1'b0; pif.in_valid = 1'b0;
    #1;
    check("abort_out_valid", pif.out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", pif.in_ready, 0);
    check("abort_done", done, 0);
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      #1;
      check("abort_no_done", done, 0);
    end
    build_exp(1);
    run_frame(4, 4, 1, 0);

    // Asynchronous reset mid-RUN with a beat pending.
    @(negedge clk);
    cfg_w = 5'd4; cfg_h = 4'd4; cfg_s = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pix = 0;
    for (int t = 0; t < 50 && pix < 6; t++) begin
      @(negedge clk);
      pif.out_ready = 1'b1; pif.in_valid = 1'b1; pif.in_data = PIX_W'(pix);
      #1;
      if (pif.in_valid && pif.in_ready) pix++;
    end
    @(negedge clk);
    pif.in_valid = 1'b0; pif.out_ready = 1'b0;
    #1;
    check("rst_pre_out_valid", pif.out_valid, 1);
    check("rst_pre_out_x", pif.out_x, 1);
    check("rst_pre_out_data", pif.out_data, 5);
    #1;
    rst_ni = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    check_idle_outputs("post_reset");
    build_exp(0);
    run_frame(4, 4, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
